// File: rtl/mem_hs.sv
// Word memory with valid/ready request/response handshake, byte strobes,
// address checking, configurable read latency and a clear sweep after reset.
module mem_hs #(
  parameter int unsigned       DATA_W  = 32,
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DEPTH   = 1024,
  parameter int unsigned       LATENCY = 1,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int unsigned       BYTES      = DATA_W / 8;
  localparam int unsigned       OFF_W      = $clog2(BYTES);
  localparam int unsigned       IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   SPAN       = (ADDR_W + 1)'(DEPTH * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BYTES - 1);
  localparam logic [3:0]        LAT_M1     = 4'(LATENCY - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              init_done_q;

  logic [ADDR_W-1:0] offset;
  logic              addr_err;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [BYTES-1:0]  mem_be;

  // Offset is taken at full width so an address above the window can never
  // alias back into it through index truncation.
  always_comb begin
    offset   = req_addr - BASE;
    addr_err = ((req_addr & ALIGN_MASK) != '0) || (req_addr < BASE) ||
               ({1'b0, offset} >= SPAN);
    idx      = IDX_W'(offset >> OFF_W);
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = idx;
    mem_wdata  = req_wdata;
    mem_be     = req_wstrb;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_idx   = clr_ptr_q;
        mem_wdata = '0;
        mem_be    = '1;
        if (clr_ptr_q == LAST_IDX) state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          mem_we  = req_wen && !addr_err;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ptr_q   <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      if (state_q == S_INIT) begin
        clr_ptr_q <= clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_IDX) init_done_q <= 1'b1;
      end
      if (state_q == S_WAIT) cnt_q <= cnt_q - 1'b1;
      if (accept) begin
        cnt_q   <= LAT_M1;
        err_q   <= addr_err;
        rdata_q <= (req_wen || addr_err) ? '0 : mem[idx];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_mem_hs.sv
// Directed bench for mem_hs: a LATENCY=2 instance driven from a vector table
// plus hand sequences, and a LATENCY=1 instance for back-to-back timing.
module tb_mem_hs;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err, init_done;
  logic [31:0] resp_rdata;

  logic        b_req_valid, b_req_ready, b_req_wen;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_resp_valid, b_resp_ready, b_resp_err, b_init_done;
  logic [31:0] b_resp_rdata;

  mem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .LATENCY(LAT), .BASE(32'h8000_0000)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .init_done(init_done)
  );

  mem_hs #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .LATENCY(1), .BASE(32'h8000_0000)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(b_req_wen),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .init_done(b_init_done)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered at a sample point in the first cycle after reset release.
  task automatic sweep_check(input string tag);
    int n = 0;
    int saw_resp = 0;
    while (!req_ready && n < 40) begin
      if (resp_valid) saw_resp = 1;
      tick();
      n++;
    end
    check({tag, " ready-low cycles"}, n, 16);
    check({tag, " init_done"}, init_done, 1);
    check({tag, " no stray resp"}, saw_resp, 0);
  endtask

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                        input logic exp_err, input string tag);
    int n = 0;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    while (!req_ready && n < 40) begin tick(); n++; end
    check({tag, " ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin tick(); n++; end
    check({tag, " latency"}, n, LAT - 1);
    check({tag, " rdata"}, resp_rdata, exp_rdata);
    check({tag, " err"}, resp_err, exp_err);
    tick();
  endtask

  vec_t vecs[19];
  vec_t bv[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    vecs[1]  = '{1'b1, 32'h8000_0004, 32'h0000_00AA, 4'h1, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[3]  = '{1'b0, 32'h8000_0040, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[4]  = '{1'b0, 32'h8000_0002, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'h1122_3344, 4'h0, 32'h0, 1'b0};
    vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 32'h8000_003C, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    vecs[10] = '{1'b0, 32'h8000_003C, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0040, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 32'h8000_0005, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1};
    vecs[14] = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[15] = '{1'b1, 32'h8000_0008, 32'hAABB_CCDD, 4'hA, 32'h0, 1'b0};
    vecs[16] = '{1'b0, 32'h8000_0008, 32'h0, 4'h0, 32'hAA00_CC00, 1'b0};
    vecs[17] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1'b1};
    vecs[18] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h0, 1'b1};

    bv[0] = '{1'b1, 32'h8000_0000, 32'h0000_A5A5, 4'hF, 32'h0, 1'b0};
    bv[1] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_A5A5, 1'b0};
    bv[2] = '{1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0, 1'b0};
    bv[3] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_A5A5, 1'b0};

    reset = 1'b1;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
    b_resp_ready = 1'b1;

    tick(); tick(); tick();
    check("reset req_ready", req_ready, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset rdata", resp_rdata, 0);
    check("reset err", resp_err, 0);
    check("reset init_done", init_done, 0);
    reset = 1'b0;
    sweep_check("sweep1");

    for (int i = 0; i < 16; i++)
      do_req(1'b0, 32'h8000_0000 + 32'(i * 4), '0, '0, 32'h0, 1'b0, $sformatf("clear[%0d]", i));

    for (int i = 0; i < 19; i++)
      do_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec[%0d]", i));

    begin : backpressure
      int n = 0;
      resp_ready = 1'b0;
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0004;
      check("bp first ready", req_ready, 1);
      tick();
      req_addr = 32'h8000_003C;
      while (!resp_valid && n < 40) begin tick(); n++; end
      check("bp latency", n, LAT - 1);
      for (int i = 0; i < 5; i++) begin
        check($sformatf("bp hold valid[%0d]", i), resp_valid, 1);
        check($sformatf("bp hold rdata[%0d]", i), resp_rdata, 32'hDEAD_BEAA);
        check($sformatf("bp hold err[%0d]", i), resp_err, 0);
        check($sformatf("bp hold ready[%0d]", i), req_ready, 0);
        if (i < 4) tick();
      end
      resp_ready = 1'b1;
      tick();
      check("bp after hs valid", resp_valid, 0);
      check("bp after hs ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      check("bp second accepted", req_ready, 0);
      n = 0;
      while (!resp_valid && n < 40) begin tick(); n++; end
      check("bp second latency", n, LAT - 1);
      check("bp second rdata", resp_rdata, 32'hCAFE_F00D);
      tick();
    end

    do_req(1'b1, 32'h8000_0008, 32'h1234_5678, 4'hF, 32'h0, 1'b0, "pre-reset write");
    do_req(1'b0, 32'h8000_0008, '0, '0, 32'h1234_5678, 1'b0, "pre-reset read");
    begin : reset_in_wait
      req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0008;
      check("rw ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      check("rw in wait", resp_valid, 0);
      reset = 1'b1;
      tick();
      check("rw reset valid", resp_valid, 0);
      check("rw reset rdata", resp_rdata, 0);
      check("rw reset init_done", init_done, 0);
      reset = 1'b0;
      sweep_check("sweep2");
      do_req(1'b0, 32'h8000_0008, '0, '0, 32'h0, 1'b0, "post-reset read");
    end

    begin : latency1
      int n = 0;
      while (!(b_init_done && b_req_ready) && n < 60) begin tick(); n++; end
      check("l1 init_done", b_init_done, 1);
      b_req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        check($sformatf("l1 ready[%0d]", k), b_req_ready, (k % 2 == 0) ? 1 : 0);
        check($sformatf("l1 valid[%0d]", k), b_resp_valid, (k % 2 == 1) ? 1 : 0);
        if (k % 2 == 1) begin
          check($sformatf("l1 rdata[%0d]", k), b_resp_rdata, bv[k/2].exp_rdata);
          check($sformatf("l1 err[%0d]", k), b_resp_err, bv[k/2].exp_err);
        end else begin
          b_req_wen = bv[k/2].wen; b_req_addr = bv[k/2].addr;
          b_req_wdata = bv[k/2].wdata; b_req_wstrb = bv[k/2].wstrb;
        end
        tick();
      end
      b_req_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_hs.md
# mem_hs

Parametrised, synthesizable word memory with a valid/ready request/response handshake. It is the next-generation data/instruction memory for the miniRV core. Width, depth, base address and read latency are configurable, byte strobes are supported, and out-of-range or misaligned accesses are flagged. After reset the storage is zeroed by a hardware sweep, so contents are deterministic without simulator hooks.

## Interface
- DATA_W, 32: word width in bits; multiple of 8, at least 8.
- ADDR_W, 32: byte-address width.
- DEPTH, 1024: number of words; power of two, at least 2.
- LATENCY, 1: cycles from request acceptance to resp_valid; legal range 1..15.
- BASE, 32'h8000_0000: byte address of word 0; aligned to DEPTH*DATA_W/8.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_wstrb  in  DATA_W/8  byte enables for writes; bit i covers byte i.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- resp_err  out  1  access was out of range or misaligned.
- init_done  out  1  high once the clear sweep is finished; stays high until the next reset.

## Operation
- FSM states:
  - INIT: clear pointer runs 0..DEPTH-1 and writes zero to one word per cycle. req_ready=0. After the DEPTH-1 write, go to IDLE and set init_done.
  - IDLE: req_ready=1. On accept:
    - Latch req_wen, check address, and load the latency counter with LATENCY-1.
    - Go to RESP if LATENCY==1, else go to WAIT.
  - WAIT: req_ready=0. Decrement the counter; go to RESP when it reaches 0.
  - RESP: resp_valid=1. Outputs hold stable until resp_ready; on handshake, go to IDLE.
- Address check:
  - Error if the req_addr low log2(DATA_W/8) bits are nonzero.
  - Error if req_addr < BASE or req_addr >= BASE + DEPTH*DATA_W/8.
  - On error: no array access, resp_err=1, resp_rdata=0.
- Index is (req_addr-BASE) >> log2(DATA_W/8). Compute the subtraction at ADDR_W bits; no wrap into range.
- Write: committed on the accept edge. Only bytes with a set wstrb bit change. wstrb=0 is legal (no change, normal response, err=0).
- Read: array word sampled on the accept edge and held in a response register until handshake. A read accepted after a write sees that write.
- Only one request is outstanding at a time; there is no pipelining.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0, FSM=INIT, clear pointer=0.
- Reset release: the first cycle with reset low is INIT word 0. init_done and req_ready rise in cycle DEPTH after release.
- Accept at edge t: resp_valid is high in the cycle after edge t+LATENCY-1. For LATENCY=1, that is the cycle right after acceptance.
- req_ready is high only in IDLE. The minimum accept-to-accept interval is LATENCY+1 cycles with resp_ready held high.
- Backpressure: while resp_ready=0, resp_valid, resp_rdata and resp_err hold and no new request is accepted.
- Reset in any state, including mid-INIT, WAIT or RESP:
  - Discard the in-flight response and return to INIT with the pointer at 0.
  - A write already committed on an earlier edge is later zeroed by the sweep.
  - A write presented in the same cycle as reset is not committed.
- Inputs are sampled only at handshake edges. Changes to req_* while req_ready=0 have no effect.

## Test plan
Bench parameters: DEPTH=16, LATENCY=2, DATA_W=32, BASE=0x8000_0000.

- Reset, then release: req_ready=0 for 16 cycles; init_done and req_ready rise in cycle 16; a read of every address then returns 0 with err=0.
- Write 0xDEADBEEF to 0x8000_0004 (wstrb=0xF), then write 0x000000AA with wstrb=0x1, then read: rdata=0xDEADBEAA. Each resp_valid arrives 2 cycles after accept.
- Read 0x8000_0040 (out of range), 0x8000_0002 (misaligned) and 0x7FFF_FFFC (below base): err=1, rdata=0. A following read of 0x8000_0000 returns the prior contents unchanged.
- Hold resp_ready=0 for 5 cycles on a read of 0x8000_0004: resp_valid and rdata stay stable, req_ready=0, and a second request held on req_valid is accepted only the cycle after the handshake.
- Write 0x12345678 to 0x8000_0008, then assert reset during the WAIT cycle of a following read: no response appears, the sweep reruns for 16 cycles, and a read of 0x8000_0008 returns 0.
- LATENCY=1 build: back-to-back reads with resp_ready=1 are accepted every 2 cycles, and resp_valid is high in the cycle right after each accept.
